// File: rtl/fetch_pkg.sv
// Shared types for the fetch path: RAM address width, address type and the
// address-sequencer state encoding.
package fetch_pkg;

    localparam int FETCH_A_S = 8;

    typedef logic [FETCH_A_S-1:0] fetch_addr_t;

    typedef enum logic {
        FAG_IDLE  = 1'b0,
        FAG_ISSUE = 1'b1
    } fag_state_e;

endpackage

// File: rtl/fetch_addr_gen_if.sv
// Command and address-stream signals of the burst address sequencer.
// Handshakes: a transfer happens in any cycle where valid and ready are both 1;
// once valid is raised it holds, with its payload stable, until that transfer.
interface fetch_addr_gen_if #(
    parameter int A_S = 8
);
    logic           cmd_vld;
    logic [A_S-1:0] cmd_base;
    logic [7:0]     cmd_len;
    logic           cmd_rdy;
    logic           m_vld;
    logic [A_S-1:0] m_cnt;
    logic           m_last;
    logic           m_rdy;
    logic           busy;
    logic           done;

    // Sequencer side: takes commands, drives the address stream.
    modport master (
        input  cmd_vld, cmd_base, cmd_len, m_rdy,
        output cmd_rdy, m_vld, m_cnt, m_last, busy, done
    );

    // Environment side: issues commands, consumes the address stream.
    modport slave (
        output cmd_vld, cmd_base, cmd_len, m_rdy,
        input  cmd_rdy, m_vld, m_cnt, m_last, busy, done
    );
endinterface

// File: rtl/fetch_addr_gen.sv
// Burst address sequencer: one (base, len) command at a time becomes len+1
// consecutive addresses, wrapping modulo 2^A_S, with a done pulse at the end.
module fetch_addr_gen
    import fetch_pkg::*;
#(
    parameter int A_S    = FETCH_A_S,
    parameter int STRIDE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    fetch_addr_gen_if.master       bus,
    output fag_state_e             dbg_state
);

    fag_state_e     state;
    logic           m_vld;
    logic [A_S-1:0] m_cnt;
    logic [7:0]     beats_left;
    logic           done;

    logic beat_hs;
    logic on_last;
    logic cmd_rdy;

    assign on_last = (beats_left == 8'd0);
    assign beat_hs = m_vld & bus.m_rdy;
    // Ready on the last-beat handshake lets the next burst follow with no bubble.
    assign cmd_rdy = (state == FAG_IDLE) | (beat_hs & on_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FAG_IDLE;
            m_vld      <= 1'b0;
            m_cnt      <= '0;
            beats_left <= 8'd0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                FAG_IDLE: begin
                    if (bus.cmd_vld) begin
                        state      <= FAG_ISSUE;
                        m_vld      <= 1'b1;
                        m_cnt      <= bus.cmd_base;
                        beats_left <= bus.cmd_len;
                    end
                end
                FAG_ISSUE: begin
                    if (beat_hs) begin
                        if (!on_last) begin
                            m_cnt      <= m_cnt + A_S'(STRIDE);
                            beats_left <= beats_left - 8'd1;
                        end else begin
                            done <= 1'b1;
                            if (bus.cmd_vld) begin
                                m_cnt      <= bus.cmd_base;
                                beats_left <= bus.cmd_len;
                            end else begin
                                state <= FAG_IDLE;
                                m_vld <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state <= FAG_IDLE;
                    m_vld <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_rdy = cmd_rdy;
    assign bus.m_vld   = m_vld;
    assign bus.m_cnt   = m_cnt;
    assign bus.m_last  = m_vld & on_last;
    assign bus.busy    = (state == FAG_ISSUE);
    assign bus.done    = done;
    assign dbg_state   = state;

endmodule

// File: doc/fetch_addr_gen.md
# fetch_addr_gen

Burst address sequencer that sits directly upstream of the fetch controller and drives its `s0_vld`/`s0_cnt`/`s0_rdy` address port. It accepts one burst command at a time (base address, beat count) and issues consecutive RAM addresses under a valid/ready handshake. It wraps modulo the address space and flags the final beat. A one-cycle completion pulse follows the last accepted address.

## Interface
- `A_S`, 8: address width; matches the fetch controller RAM address width.
- `STRIDE`, 1: address increment per beat, range 1..2^A_S-1.
- `clk` in 1: clock; all logic on posedge.
- `rst` in 1: reset; one clock, synchronous, active-high.
- `cmd_vld` in 1: burst command valid.
- `cmd_base` in A_S: first address of burst.
- `cmd_len` in 8: beats minus one (0 = 1 beat, 255 = 256 beats).
- `cmd_rdy` out 1: command accepted when `cmd_vld & cmd_rdy`.
- `m_vld` out 1: address valid; connects to fetch controller `s0_vld`.
- `m_cnt` out A_S: address; connects to `s0_cnt`.
- `m_last` out 1: current address is the final beat of the burst.
- `m_rdy` in 1: downstream ready; connects to `s0_rdy`.
- `busy` out 1: burst in progress (state ISSUE).
- `done` out 1: one-cycle pulse after the last beat handshake.

## Operation
- FSM states: IDLE, ISSUE. Encoded as an enum.
- IDLE -> ISSUE on a command handshake. Latches `m_cnt <= cmd_base` and `beats_left <= cmd_len`. Sets `m_vld <= 1`.
- In ISSUE, on a handshake `m_vld & m_rdy`:
  - not last: `m_cnt <= m_cnt + STRIDE`, truncated to A_S bits (wraps 2^A_S-1 -> 0 for STRIDE=1); `beats_left <= beats_left - 1`.
  - last (`beats_left == 0`): `done <= 1` next cycle. If a new command handshakes in the same cycle, reload and stay in ISSUE with `m_vld` held at 1. Otherwise go to IDLE with `m_vld <= 0`.
- `m_last = m_vld & (beats_left == 0)`, combinational from registers.
- `cmd_rdy = (state == IDLE) | (m_vld & m_rdy & m_last)`. This gives zero-bubble back-to-back bursts. `cmd_rdy` is the only output with a combinational path, and that path runs from `m_rdy` only.
- With `m_vld` high and `m_rdy` low, `m_cnt` and `m_last` hold stable and `m_vld` never drops.
- Commands offered while busy and not on the last beat are ignored: `cmd_rdy` is 0 and there is no queueing.
- `done` is set only by a last-beat handshake; it clears the following cycle.

## Timing
- Reset values: `m_vld=0`, `m_cnt=0`, `m_last=0`, `busy=0`, `done=0`, state IDLE. `cmd_rdy=1` from the first cycle after reset.
- Reset mid-burst drops `m_vld` the cycle after `rst` is sampled. The burst is discarded and no `done` is produced.
- Command handshake in cycle N: `m_vld=1`, `m_cnt=base` in N+1.
- With `m_rdy` held at 1: one address per cycle, so a burst of L+1 beats occupies cycles N+1..N+L+1. `done` is high in N+L+2.
- Back-to-back command on the last beat: the next burst's first address appears in the cycle immediately after the last handshake, with no idle cycle. `done` for the prior burst pulses in that same cycle.
- The fetch controller's `s0_rdy` deasserts for a cycle after each accept unless built with its ready-propagation option. This block must tolerate any `m_rdy` pattern with no lost or duplicated addresses.

## Structure
- Package `fetch_pkg`:
  - `localparam FETCH_A_S = 8`.
  - typedef `fetch_addr_t` (logic [FETCH_A_S-1:0]).
  - enum `fag_state_e` {FAG_IDLE, FAG_ISSUE}.
  - The fetch controller imports this package as well.
- No sub-module: one FSM, one address register, one 8-bit down-counter. Target roughly 150 lines.

## Test plan
- Reset then command base=0x10, len=3, `m_rdy`=1 -> addresses 0x10,0x11,0x12,0x13 on consecutive cycles; `m_last` on 0x13 only; `done` one cycle later; `busy` falls with it.
- Wrap: base=0xFE, len=3 -> 0xFE,0xFF,0x00,0x01.
- With STRIDE=4: base=0xF8, len=2 -> 0xF8,0xFC,0x00.
- Backpressure: `m_rdy` toggling 1,0,0,1,… (fetch controller pattern) -> `m_cnt` stable during stalls; exactly len+1 unique handshakes; `m_vld` never drops mid-burst.
- Back-to-back: second command (base=0x80, len=0) held valid during the first burst -> accepted only on the first burst's last-beat handshake; 0x80 is issued in the next cycle with no bubble; two `done` pulses total.
- Reset asserted mid-burst after 2 of 5 beats -> `m_vld=0` the next cycle, no `done`; a new command afterwards restarts cleanly from its base.
- Max length: len=255 from base 0 -> 256 addresses 0x00..0xFF, `m_last` on 0xFF.
